// File: rtl/ping_pong_pkg.sv
// Shared types and default constants for the ping-pong paddle controller.
package ping_pong_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ARMED    = 2'd1,
        HIT      = 2'd2,
        COOLDOWN = 2'd3
    } paddle_state_t;

    localparam real DEF_CLK_FREQ = 1.0e4;
    localparam real DEF_X_LO     = 4.0;
    localparam real DEF_X_HI     = 5.0;
    localparam real DEF_F        = 0.8;

    // Velocity loaded into the plant on a hit; written without unary minus on reals.
    function automatic real post_hit_v(input real f, input real v);
        return (0.0 - f) * v;
    endfunction

endpackage

// File: rtl/ping_pong_band_check.sv
// Combinational classification of one plant sample against the paddle band
// and the safe envelope [0, X_HI].
module ping_pong_band_check #(
    parameter real X_LO = 4.0,
    parameter real X_HI = 5.0
) (
    input  real  x_in,
    input  real  v_in,
    input  logic x_valid,
    output logic in_band,
    output logic below,
    output logic out_of_envelope
);

    assign in_band         = x_valid && (x_in >= X_LO) && (x_in <= X_HI) && (v_in >= 0.0);
    assign below           = x_valid && (x_in >= 0.0) && (x_in < X_LO);
    assign out_of_envelope = x_valid && ((x_in < 0.0) || (x_in > X_HI));

endmodule

// File: rtl/ping_pong_paddle_ctrl.sv
// Event-triggered paddle controller: arms below the band, issues one hit request
// per band entry, holds it until acknowledged, then cools down.
// Optional build macro PADDLE_CTRL_ASSERT_EN adds a property checker.
module ping_pong_paddle_ctrl
    import ping_pong_pkg::*;
#(
    parameter real CLK_FREQ     = DEF_CLK_FREQ,
    parameter real X_LO         = DEF_X_LO,
    parameter real X_HI         = DEF_X_HI,
    parameter real F            = DEF_F,
    parameter int  COOLDOWN_CYC = 16,
    parameter int  CNT_W        = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  real              x_in,
    input  real              v_in,
    input  logic             x_valid,
    output logic             hit_req,
    output real              hit_v,
    input  logic             hit_ack,
    output logic [CNT_W-1:0] hit_cnt,
    output logic [1:0]       state,
    output logic             fault
);

    localparam int               CD_W    = (COOLDOWN_CYC > 1) ? $clog2(COOLDOWN_CYC) : 1;
    localparam logic [CD_W-1:0]  CD_LOAD = CD_W'(COOLDOWN_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    if (!((CLK_FREQ > 0.0) && (F >= 0.0) && (COOLDOWN_CYC >= 1) && (CNT_W >= 1))) begin : g_bad_config
        $error("ping_pong_paddle_ctrl: invalid parameter set");
    end

    paddle_state_t    state_r, state_nxt_s;
    logic             hit_req_r, hit_req_nxt_s;
    real              hit_v_r, hit_v_nxt_s;
    logic [CNT_W-1:0] hit_cnt_r, hit_cnt_nxt_s;
    logic [CD_W-1:0]  cd_cnt_r, cd_cnt_nxt_s;
    logic             fault_r, fault_nxt_s;
    logic             in_band_s, below_s, out_env_s;

    ping_pong_band_check #(
        .X_LO (X_LO),
        .X_HI (X_HI)
    ) u_band (
        .x_in            (x_in),
        .v_in            (v_in),
        .x_valid         (x_valid),
        .in_band         (in_band_s),
        .below           (below_s),
        .out_of_envelope (out_env_s)
    );

    // Next-state and next-output logic for the paddle FSM.
    always_comb begin
        state_nxt_s   = state_r;
        hit_req_nxt_s = hit_req_r;
        hit_v_nxt_s   = hit_v_r;
        hit_cnt_nxt_s = hit_cnt_r;
        cd_cnt_nxt_s  = cd_cnt_r;
        fault_nxt_s   = fault_r | out_env_s;
        case (state_r)
            IDLE: begin
                if (below_s) begin
                    state_nxt_s = ARMED;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ARMED: begin
                if (in_band_s) begin
                    state_nxt_s   = HIT;
                    hit_req_nxt_s = 1'b1;
                    hit_v_nxt_s   = post_hit_v(F, v_in);
                end else begin
                    state_nxt_s = ARMED;
                end
            end
            HIT: begin
                if (hit_ack) begin
                    state_nxt_s   = COOLDOWN;
                    hit_req_nxt_s = 1'b0;
                    cd_cnt_nxt_s  = CD_LOAD;
                    if (hit_cnt_r != CNT_MAX) begin
                        hit_cnt_nxt_s = hit_cnt_r + CNT_W'(1);
                    end else begin
                        hit_cnt_nxt_s = hit_cnt_r;
                    end
                end else begin
                    hit_req_nxt_s = 1'b1;
                end
            end
            COOLDOWN: begin
                // The cycle the counter reads zero is the last cooldown cycle.
                if (cd_cnt_r == CD_W'(0)) begin
                    state_nxt_s = IDLE;
                end else begin
                    cd_cnt_nxt_s = cd_cnt_r - CD_W'(1);
                end
            end
            default: begin
                state_nxt_s   = IDLE;
                hit_req_nxt_s = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            hit_req_r <= 1'b0;
            hit_v_r   <= 0.0;
            hit_cnt_r <= '0;
            cd_cnt_r  <= '0;
            fault_r   <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            hit_req_r <= hit_req_nxt_s;
            hit_v_r   <= hit_v_nxt_s;
            hit_cnt_r <= hit_cnt_nxt_s;
            cd_cnt_r  <= cd_cnt_nxt_s;
            fault_r   <= fault_nxt_s;
        end
    end

    assign state   = state_r;
    assign hit_req = hit_req_r;
    assign hit_v   = hit_v_r;
    assign hit_cnt = hit_cnt_r;
    assign fault   = fault_r;

`ifdef PADDLE_CTRL_ASSERT_EN
    ping_pong_paddle_ctrl_chk #(
        .X_HI  (X_HI),
        .CNT_W (CNT_W)
    ) u_chk (
        .clk     (clk),
        .rst     (rst),
        .x_in    (x_in),
        .x_valid (x_valid),
        .hit_req (hit_req_r),
        .hit_v   (hit_v_r),
        .hit_ack (hit_ack),
        .hit_cnt (hit_cnt_r),
        .state   (state_r),
        .fault   (fault_r)
    );
`endif

endmodule

`ifdef PADDLE_CTRL_ASSERT_EN
// Property checker bound to the controller outputs via one-cycle past registers.
module ping_pong_paddle_ctrl_chk #(
    parameter real X_HI  = 5.0,
    parameter int  CNT_W = 8
) (
    input logic             clk,
    input logic             rst,
    input real              x_in,
    input logic             x_valid,
    input logic             hit_req,
    input real              hit_v,
    input logic             hit_ack,
    input logic [CNT_W-1:0] hit_cnt,
    input logic [1:0]       state,
    input logic             fault
);

    logic             past_ok_r;
    logic             past_req_r;
    logic             past_ack_r;
    logic [CNT_W-1:0] past_cnt_r;
    logic             env_ok_r;

    // Past-value registers; env_ok_r remembers whether every sample since reset was safe.
    always_ff @(posedge clk) begin
        if (rst) begin
            past_ok_r  <= 1'b0;
            past_req_r <= 1'b0;
            past_ack_r <= 1'b0;
            past_cnt_r <= '0;
            env_ok_r   <= 1'b1;
        end else begin
            past_ok_r  <= 1'b1;
            past_req_r <= hit_req;
            past_ack_r <= hit_ack;
            past_cnt_r <= hit_cnt;
            env_ok_r   <= env_ok_r && !(x_valid && ((x_in < 0.0) || (x_in > X_HI)));
        end
    end

    a_req_in_hit: assert property (@(posedge clk) disable iff (rst) hit_req |-> (state == 2'd2));
    a_hit_v_sign: assert property (@(posedge clk) disable iff (rst) hit_req |-> (hit_v <= 0.0));
    a_req_stable: assert property (@(posedge clk) disable iff (rst)
                                   (past_ok_r && past_req_r && !past_ack_r) |-> hit_req);
    a_cnt_mono:   assert property (@(posedge clk) disable iff (rst)
                                   past_ok_r |-> (hit_cnt >= past_cnt_r));
    a_no_fault:   assert property (@(posedge clk) disable iff (rst) env_ok_r |-> !fault);

endmodule
`endif

// File: tb/tb_ping_pong_paddle_ctrl.sv
// Table-driven bench for ping_pong_paddle_ctrl, plus hand sequences for cooldown
// length and hit-counter saturation (CNT_W=2).
module tb_ping_pong_paddle_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    real        x_in = 0.0;
    real        v_in = 0.0;
    logic       x_valid = 1'b0;
    logic       hit_ack = 1'b0;
    logic       hit_req;
    real        hit_v;
    logic [1:0] hit_cnt;
    logic [1:0] state;
    logic       fault;

    int n_cmp = 0;
    int n_bad = 0;

    ping_pong_paddle_ctrl #(
        .COOLDOWN_CYC (16),
        .CNT_W        (2)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .x_in    (x_in),
        .v_in    (v_in),
        .x_valid (x_valid),
        .hit_req (hit_req),
        .hit_v   (hit_v),
        .hit_ack (hit_ack),
        .hit_cnt (hit_cnt),
        .state   (state),
        .fault   (fault)
    );

    always #5 clk = ~clk;

    // x, v and expected hit_v are stored in tenths.
    typedef struct packed {
        logic       rst;
        logic       valid;
        logic       ack;
        int         x_t;
        int         v_t;
        logic [1:0] st;
        logic       req;
        logic       chk_hv;
        int         hv_t;
        logic [1:0] cnt;
        logic       fault;
    } vec_t;

    vec_t vecs[21];

    function automatic vec_t mk(input logic r, input logic vl, input logic ak, input int xt,
                                input int vt, input logic [1:0] st, input logic rq,
                                input logic ch, input int hv, input logic [1:0] cn,
                                input logic fl);
        vec_t t;
        t.rst = r; t.valid = vl; t.ack = ak; t.x_t = xt; t.v_t = vt;
        t.st = st; t.req = rq; t.chk_hv = ch; t.hv_t = hv; t.cnt = cn; t.fault = fl;
        return t;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_r(input string name, input real act, input real exp);
        real d;
        n_cmp++;
        d = act - exp;
        if (d < 0.0) d = 0.0 - d;
        if (d > 1.0e-9) begin
            n_bad++;
            $display("FAIL %s: got %f, expected %f", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_row(input int i);
        vec_t t;
        t       = vecs[i];
        rst     = t.rst;
        x_valid = t.valid;
        hit_ack = t.ack;
        x_in    = real'(t.x_t) / 10.0;
        v_in    = real'(t.v_t) / 10.0;
        step();
        chk($sformatf("row%0d state", i), int'(state), int'(t.st));
        chk($sformatf("row%0d hit_req", i), int'(hit_req), int'(t.req));
        chk($sformatf("row%0d hit_cnt", i), int'(hit_cnt), int'(t.cnt));
        chk($sformatf("row%0d fault", i), int'(fault), int'(t.fault));
        if (t.chk_hv) chk_r($sformatf("row%0d hit_v", i), hit_v, real'(t.hv_t) / 10.0);
    endtask

    initial begin
        //            rst vl ak  x    v   st req chk hv  cnt flt
        vecs[0]  = mk(1, 0, 0,   0,   0, 0, 0, 1,   0, 0, 0); // reset
        vecs[1]  = mk(0, 1, 0,  30,   5, 1, 0, 0,   0, 0, 0); // below -> ARMED
        vecs[2]  = mk(0, 0, 0,  42,  10, 1, 0, 0,   0, 0, 0); // invalid sample freezes
        vecs[3]  = mk(0, 1, 0,  42,  10, 2, 1, 1,  -8, 0, 0); // in band -> HIT
        vecs[4]  = mk(0, 0, 0,   0,   0, 2, 1, 1,  -8, 0, 0);
        vecs[5]  = mk(0, 0, 0,   0,   0, 2, 1, 1,  -8, 0, 0);
        vecs[6]  = mk(0, 0, 1,   0,   0, 3, 0, 0,   0, 1, 0); // ack -> COOLDOWN
        vecs[7]  = mk(0, 1, 1,  45,  10, 0, 0, 0,   0, 1, 0); // ack/in band in IDLE ignored
        vecs[8]  = mk(0, 1, 0,  45,  10, 0, 0, 0,   0, 1, 0);
        vecs[9]  = mk(0, 1, 0,  52,  10, 0, 0, 0,   0, 1, 1); // above envelope
        vecs[10] = mk(0, 1, 0,  20,  -3, 1, 0, 0,   0, 1, 1); // fault sticky, arms
        vecs[11] = mk(0, 1, 0,  50,  -1, 1, 0, 0,   0, 1, 1); // v<0 not in band
        vecs[12] = mk(0, 1, 0,  50,   0, 2, 1, 1,   0, 1, 1); // x=X_HI, v=0 in band
        vecs[13] = mk(0, 0, 1,   0,   0, 3, 0, 0,   0, 2, 1);
        vecs[14] = mk(1, 0, 0,   0,   0, 0, 0, 1,   0, 0, 0); // rst clears fault
        vecs[15] = mk(0, 1, 0,  -5,   0, 0, 0, 0,   0, 0, 1); // x<0: fault, no arm
        vecs[16] = mk(1, 0, 0,   0,   0, 0, 0, 1,   0, 0, 0);
        vecs[17] = mk(0, 1, 0,  40,  25, 0, 0, 0,   0, 0, 0); // x=X_LO is not below
        vecs[18] = mk(0, 1, 0,  39,  25, 1, 0, 0,   0, 0, 0);
        vecs[19] = mk(0, 1, 0,  40,  25, 2, 1, 1, -20, 0, 0); // x=X_LO in band
        vecs[20] = mk(1, 0, 0,   0,   0, 0, 0, 1,   0, 0, 0); // rst during HIT

        for (int i = 0; i <= 6; i++) run_row(i);

        // Cooldown lasts 16 cycles; samples (incl. below-band) and ack are ignored.
        x_valid = 1'b1; x_in = 3.0; v_in = 0.5; hit_ack = 1'b1;
        for (int k = 0; k < 15; k++) begin
            step();
            chk($sformatf("cooldown%0d state", k), int'(state), 3);
            chk($sformatf("cooldown%0d hit_cnt", k), int'(hit_cnt), 1);
        end
        step();
        chk("cooldown_end state", int'(state), 0);
        hit_ack = 1'b0;

        for (int i = 7; i <= 20; i++) run_row(i);

        // Five full hits with a 2-bit counter: 1,2,3,3,3.
        rst = 1'b0;
        for (int n = 1; n <= 5; n++) begin
            x_valid = 1'b1; hit_ack = 1'b0; x_in = 3.0; v_in = 0.5;
            step();
            chk($sformatf("sat%0d armed", n), int'(state), 1);
            x_in = 4.5; v_in = 1.0;
            step();
            chk($sformatf("sat%0d hit_req", n), int'(hit_req), 1);
            chk_r($sformatf("sat%0d hit_v", n), hit_v, -0.8);
            x_valid = 1'b0; hit_ack = 1'b1;
            step();
            chk($sformatf("sat%0d req_drop", n), int'(hit_req), 0);
            chk($sformatf("sat%0d hit_cnt", n), int'(hit_cnt), (n > 3) ? 3 : n);
            hit_ack = 1'b0;
            repeat (15) step();
            chk($sformatf("sat%0d cooling", n), int'(state), 3);
            step();
            chk($sformatf("sat%0d idle", n), int'(state), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
